// File: rtl/frame_ram_writer.sv
// Captures one frame of pixels into an on-chip RAM, flags short/long frames,
// and provides a registered random-access readback port.
module frame_ram_writer #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] wr_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err_short,
    output logic                  err_long,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int RAM_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DATA_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                  err_short_q, err_short_d;
    logic                  err_long_q, err_long_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  accept;
    logic                  at_last;

    logic [DATA_WIDTH-1:0] ram [DATA_DEPTH];

    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;
        accept      = (state_q == S_CAPTURE) && in_valid;
        at_last     = (wr_count_q == LAST_IDX);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_CAPTURE;
                    wr_count_d  = '0;
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                end
            end
            S_CAPTURE: begin
                // start is deliberately not looked at here
                if (accept) begin
                    wr_count_d = wr_count_q + 1'b1;
                    if (in_last || at_last) begin
                        state_d     = S_DONE;
                        err_short_d = in_last && !at_last;
                        err_long_d  = !in_last && at_last;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
        rd_data_d = (rd_addr < DEPTH_A) ? ram[rd_addr[RAM_AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_count_q  <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // RAM is never reset; an abandoned frame leaves its partial data behind.
    // accept only fires below DATA_DEPTH, so the index never leaves the array.
    always_ff @(posedge clk) begin
        if (accept) begin
            ram[wr_count_q[RAM_AW-1:0]] <= in_data;
        end
    end

    assign in_ready  = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_count  = wr_count_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign rd_data   = rd_data_q;

endmodule
